if_fetch_stage: RTL and testbench
=================================

// Module: if_fetch_stage
// PURPOSE
//  LC-3b pipeline instruction-fetch stage; sits directly upstream of the IF/ID buffer.
//  Holds the PC and issues word reads to instruction memory (read/resp handshake).
//  Presents {valid, pc, pc+2, instruction} to IF/ID, honouring downstream stall and
//  branch/jump redirects from later stages. Discards in-flight fetches on redirect.
// PARAMETERS
//  PC_RESET   16'h0000  PC value loaded on reset
// PORTS
//  clk             in   1   pipeline clock, all state on rising edge
//  reset_n         in   1   synchronous reset, active-low
//  imem_read       out  1   instruction memory read request
//  imem_address    out  16  fetch address; stable while imem_read=1 until imem_resp
//  imem_rdata      in   16  instruction word, valid when imem_resp=1
//  imem_resp       in   1   memory response, 1-cycle pulse
//  stall           in   1   IF/ID cannot accept this cycle (hazard/downstream stall)
//  br_taken        in   1   redirect pulse from later stage
//  br_target       in   16  redirect PC, sampled when br_taken=1
//  if_valid        out  1   output slot holds a real instruction
//  if_pc           out  16  address of if_instruction
//  if_pc_plus2     out  16  if_pc + 2 (mod 2^16)
//  if_instruction  out  16  fetched word; 16'h0000 (BR nop) when not valid
// BEHAVIOUR
//  Reset (reset_n=0 at edge): pc=PC_RESET, state=IDLE, imem_read=0, imem_address=PC_RESET,
//   if_valid=0, if_pc=0, if_pc_plus2=0, if_instruction=16'h0000, hold buffer empty.
//   Reset mid-fetch abandons the outstanding request (imem_read drops next edge).
//  Output slot: consumed at any edge where stall=0; if_valid clears on consume unless refilled.
//  States:
//   IDLE    imem_read=0; next edge -> FETCH with fetch_addr=pc.
//   FETCH   imem_read=1, imem_address=fetch_addr. On imem_resp:
//           - slot empty or consumed this edge: load slot {1, fetch_addr, fetch_addr+2,
//             rdata}; pc=fetch_addr=fetch_addr+2; stay FETCH (back-to-back, 1 instr/resp).
//           - slot full and stall=1: capture into hold buffer, pc+=2, -> HOLD.
//   HOLD    imem_read=0; on first edge with stall=0 move hold buffer to slot, -> FETCH.
//   DISCARD imem_read=1 at old fetch_addr until imem_resp; response dropped;
//           then fetch_addr=pc, -> FETCH.
//  Redirect (br_taken=1) has priority over stall and resp:
//   - slot and hold buffer invalidated at that edge (if_valid=0 next cycle); pc=br_target.
//   - FETCH without resp same cycle -> DISCARD (request never cancelled mid-handshake).
//   - FETCH with resp same cycle, HOLD, IDLE -> FETCH, fetch_addr=br_target, data dropped.
//   - DISCARD -> stay DISCARD, pc updated to newest target (last redirect wins).
//  Fetch latency: first instruction valid 1 cycle after imem_resp; min 2 cycles after reset release.
//  Arithmetic: PC is 16-bit, +2 wraps 16'hFFFE -> 16'h0000; br_target[0] ignored (forced 0).
//  Invariant: imem_address never changes while imem_read=1 and no resp received.
// CONFIGURATION
//  IF_PERF_CNT_EN defined: adds outputs perf_fetch_cnt[31:0] (instructions delivered,
//   i.e. slot consumed with if_valid=1) and perf_bubble_cnt[31:0] (cycles with stall=0
//   and if_valid=0); both reset to 0, saturate at 32'hFFFFFFFF, cleared by reset only.
//  Undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  1 Reset release, mem resp every 2nd cycle, stall=0 -> imem_address 0000,0002,0004;
//    if_pc sequence 0000,0002,0004 each with if_valid=1 for 1 cycle.
//  2 stall=1 for 5 cycles with slot full and resp arriving -> HOLD, imem_read=0,
//    if_instruction unchanged; stall release -> held word delivered, no loss/duplication.
//  3 br_taken, br_target=16'h3000 while request to 0006 outstanding -> imem_read stays
//    at 0006 until resp, word dropped, next address 3000, first valid if_pc=3000.
//  4 br_taken same cycle as imem_resp and stall=1 -> if_valid=0 next cycle, next fetch 3000.
//  5 PC_RESET=16'hFFFC, continuous fetch -> if_pc FFFC,FFFE,0000; if_pc_plus2 at FFFE = 0000.
//  6 reset_n low for 1 cycle mid-fetch -> all outputs return to reset values next edge;
//    with IF_PERF_CNT_EN, perf counters read 0 and increment per test 1 counts.

Source files
------------

// File: rtl/if_fetch_stage.sv
// LC-3b instruction-fetch stage: owns the PC, fetches over a read/resp handshake and feeds IF/ID.
// Optional IF_PERF_CNT_EN adds saturating delivered-instruction and bubble counters.
module if_fetch_stage #(
  parameter logic [15:0] PC_RESET = 16'h0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_read,
  output logic [15:0] imem_address,
  input  logic [15:0] imem_rdata,
  input  logic        imem_resp,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [15:0] br_target,
  output logic        if_valid,
  output logic [15:0] if_pc,
  output logic [15:0] if_pc_plus2,
  output logic [15:0] if_instruction
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_bubble_cnt
`endif
);

  localparam int unsigned XLEN = 16;

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DISCARD} state_t;

  state_t            state_q, state_nxt;
  logic [XLEN-1:0]   pc_q, pc_nxt;
  logic [XLEN-1:0]   fetch_addr_nxt;
  logic              read_nxt;
  logic              slot_valid_nxt;
  logic [XLEN-1:0]   slot_pc_nxt, slot_pc2_nxt, slot_instr_nxt;
  logic [XLEN-1:0]   hold_pc_q, hold_pc_nxt, hold_instr_q, hold_instr_nxt;
  logic [XLEN-1:0]   target, fetch_plus2;

  // Next-state, slot and hold-buffer update; redirect outranks stall and response.
  always_comb begin
    state_nxt      = state_q;
    pc_nxt         = pc_q;
    fetch_addr_nxt = imem_address;
    slot_valid_nxt = if_valid;
    slot_pc_nxt    = if_pc;
    slot_pc2_nxt   = if_pc_plus2;
    slot_instr_nxt = if_instruction;
    hold_pc_nxt    = hold_pc_q;
    hold_instr_nxt = hold_instr_q;
    target         = br_target & ~XLEN'(1);
    fetch_plus2    = imem_address + XLEN'(2);

    if (!stall) slot_valid_nxt = 1'b0;

    if (br_taken) begin
      slot_valid_nxt = 1'b0;
      pc_nxt         = target;
      // An accepted request must complete, so its response is dropped in DISCARD.
      if ((state_q == FETCH || state_q == DISCARD) && !imem_resp) begin
        state_nxt = DISCARD;
      end else begin
        state_nxt      = FETCH;
        fetch_addr_nxt = target;
      end
    end else begin
      case (state_q)
        IDLE: begin
          state_nxt      = FETCH;
          fetch_addr_nxt = pc_q;
        end
        FETCH: begin
          if (imem_resp) begin
            pc_nxt         = fetch_plus2;
            fetch_addr_nxt = fetch_plus2;
            if (!if_valid || !stall) begin
              slot_valid_nxt = 1'b1;
              slot_pc_nxt    = imem_address;
              slot_pc2_nxt   = fetch_plus2;
              slot_instr_nxt = imem_rdata;
            end else begin
              hold_pc_nxt    = imem_address;
              hold_instr_nxt = imem_rdata;
              state_nxt      = HOLD;
            end
          end
        end
        HOLD: begin
          if (!stall) begin
            slot_valid_nxt = 1'b1;
            slot_pc_nxt    = hold_pc_q;
            slot_pc2_nxt   = hold_pc_q + XLEN'(2);
            slot_instr_nxt = hold_instr_q;
            state_nxt      = FETCH;
          end
        end
        DISCARD: begin
          if (imem_resp) begin
            fetch_addr_nxt = pc_q;
            state_nxt      = FETCH;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end

    read_nxt = (state_nxt == FETCH) || (state_nxt == DISCARD);
    if (!slot_valid_nxt) slot_instr_nxt = '0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      pc_q           <= PC_RESET;
      imem_read      <= 1'b0;
      imem_address   <= PC_RESET;
      if_valid       <= 1'b0;
      if_pc          <= '0;
      if_pc_plus2    <= '0;
      if_instruction <= '0;
      hold_pc_q      <= '0;
      hold_instr_q   <= '0;
    end else begin
      state_q        <= state_nxt;
      pc_q           <= pc_nxt;
      imem_read      <= read_nxt;
      imem_address   <= fetch_addr_nxt;
      if_valid       <= slot_valid_nxt;
      if_pc          <= slot_pc_nxt;
      if_pc_plus2    <= slot_pc2_nxt;
      if_instruction <= slot_instr_nxt;
      hold_pc_q      <= hold_pc_nxt;
      hold_instr_q   <= hold_instr_nxt;
    end
  end

`ifdef IF_PERF_CNT_EN
  // Saturating counters of consumed instructions and empty-slot cycles.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      perf_fetch_cnt  <= '0;
      perf_bubble_cnt <= '0;
    end else if (!stall) begin
      if (if_valid && perf_fetch_cnt != '1)
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (!if_valid && perf_bubble_cnt != '1)
        perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: rule-level reference model checked every cycle plus directed scenarios.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        imem_read, imem_resp, stall, br_taken, if_valid;
  logic [15:0] imem_address, imem_rdata, br_target, if_pc, if_pc_plus2, if_instruction;

  logic        w_read, w_resp, w_stall, w_br, w_valid;
  logic [15:0] w_addr, w_rdata, w_tgt, w_pc, w_pc2, w_ins;

`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt, perf_bubble_cnt, w_pf, w_pb;
`endif

  if_fetch_stage #(.PC_RESET(16'h0000)) dut (
    .clk(clk), .reset_n(reset_n), .imem_read(imem_read), .imem_address(imem_address),
    .imem_rdata(imem_rdata), .imem_resp(imem_resp), .stall(stall), .br_taken(br_taken),
    .br_target(br_target), .if_valid(if_valid), .if_pc(if_pc), .if_pc_plus2(if_pc_plus2),
    .if_instruction(if_instruction)
`ifdef IF_PERF_CNT_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_bubble_cnt(perf_bubble_cnt)
`endif
  );

  if_fetch_stage #(.PC_RESET(16'hFFFC)) dut_wrap (
    .clk(clk), .reset_n(reset_n), .imem_read(w_read), .imem_address(w_addr),
    .imem_rdata(w_rdata), .imem_resp(w_resp), .stall(w_stall), .br_taken(w_br),
    .br_target(w_tgt), .if_valid(w_valid), .if_pc(w_pc), .if_pc_plus2(w_pc2),
    .if_instruction(w_ins)
`ifdef IF_PERF_CNT_EN
    , .perf_fetch_cnt(w_pf), .perf_bubble_cnt(w_pb)
`endif
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [15:0] word_of(input logic [15:0] a);
    return a ^ 16'h5A3C;
  endfunction

  // Instruction memory for the main DUT: answers after mem_wait cycles of a held request.
  int mem_wait = 2;
  int mem_cnt = 0;
  logic [15:0] resp_addr[$];
  initial begin
    imem_resp = 1'b0;
    imem_rdata = 16'h0000;
    forever begin
      @(negedge clk);
      imem_resp = 1'b0;
      if (imem_read === 1'b1 && reset_n) begin
        mem_cnt++;
        if (mem_cnt >= mem_wait) begin
          imem_resp = 1'b1;
          imem_rdata = word_of(imem_address);
          resp_addr.push_back(imem_address);
          mem_cnt = 0;
        end
      end else begin
        mem_cnt = 0;
      end
    end
  end

  // Zero-wait memory for the wrap-around instance.
  initial begin
    w_stall = 1'b0; w_br = 1'b0; w_tgt = 16'h0000; w_resp = 1'b0; w_rdata = 16'h0000;
    forever begin
      @(negedge clk);
      w_resp  = (w_read === 1'b1) && reset_n;
      w_rdata = word_of(w_addr);
    end
  end

  logic [15:0] wrap_pc[$];
  logic [15:0] wrap_p2[$];
  always @(posedge clk) begin
    #1;
    if (w_valid === 1'b1 && wrap_pc.size() < 3) begin
      wrap_pc.push_back(w_pc);
      wrap_p2.push_back(w_pc2);
    end
  end

  // Reference model: the fetch rules applied per edge to the sampled inputs.
  logic        m_known = 1'b0;
  logic        m_req, m_doomed, m_slot_v, m_held_v;
  logic [15:0] m_pc, m_addr, m_slot_pc, m_slot_ins, m_held_pc, m_held_ins, tgt;
  logic [31:0] m_fcnt, m_bcnt;
  logic        prev_valid = 1'b0;
  logic [15:0] prev_pc = 16'h0000;
  logic [15:0] seen_pc[$];

  always @(posedge clk) begin
    if (reset_n && !stall && prev_valid) seen_pc.push_back(prev_pc);
    if (!reset_n) begin
      m_known = 1'b1; m_pc = 16'h0000; m_addr = 16'h0000; m_req = 1'b0; m_doomed = 1'b0;
      m_slot_v = 1'b0; m_held_v = 1'b0; m_fcnt = 32'd0; m_bcnt = 32'd0;
    end else if (m_known) begin
      if (!stall) begin
        if (m_slot_v) m_fcnt = m_fcnt + 32'd1;
        else          m_bcnt = m_bcnt + 32'd1;
        m_slot_v = 1'b0;
      end
      if (br_taken) begin
        tgt = {br_target[15:1], 1'b0};
        m_slot_v = 1'b0; m_held_v = 1'b0; m_pc = tgt;
        if (m_req && !imem_resp) m_doomed = 1'b1;
        else begin m_req = 1'b1; m_addr = tgt; m_doomed = 1'b0; end
      end else if (m_held_v) begin
        if (!stall) begin
          m_slot_v = 1'b1; m_slot_pc = m_held_pc; m_slot_ins = m_held_ins;
          m_held_v = 1'b0; m_req = 1'b1; m_addr = m_pc;
        end
      end else if (!m_req) begin
        m_req = 1'b1; m_addr = m_pc;
      end else if (imem_resp) begin
        if (m_doomed) begin
          m_doomed = 1'b0; m_addr = m_pc;
        end else begin
          m_pc = m_addr + 16'd2;
          if (m_slot_v) begin
            m_held_v = 1'b1; m_held_pc = m_addr; m_held_ins = imem_rdata; m_req = 1'b0;
          end else begin
            m_slot_v = 1'b1; m_slot_pc = m_addr; m_slot_ins = imem_rdata; m_addr = m_pc;
          end
        end
      end
    end
    #1;
    prev_valid = (if_valid === 1'b1);
    prev_pc = if_pc;
    if (m_known) begin
      chk("imem_read", imem_read, m_req);
      if (m_req) chk("imem_address", imem_address, m_addr);
      chk("if_valid", if_valid, m_slot_v);
      if (m_slot_v) begin
        chk("if_pc", if_pc, m_slot_pc);
        chk("if_pc_plus2", if_pc_plus2, m_slot_pc + 16'd2);
        chk("if_instruction", if_instruction, m_slot_ins);
      end else begin
        chk("if_instruction_nop", if_instruction, 16'h0000);
      end
`ifdef IF_PERF_CNT_EN
      chk("perf_fetch_cnt", perf_fetch_cnt, m_fcnt);
      chk("perf_bubble_cnt", perf_bubble_cnt, m_bcnt);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_imem_read"}, imem_read, 1'b0);
    chk({tag, "_imem_address"}, imem_address, 16'h0000);
    chk({tag, "_if_valid"}, if_valid, 1'b0);
    chk({tag, "_if_pc"}, if_pc, 16'h0000);
    chk({tag, "_if_pc_plus2"}, if_pc_plus2, 16'h0000);
    chk({tag, "_if_instruction"}, if_instruction, 16'h0000);
`ifdef IF_PERF_CNT_EN
    chk({tag, "_perf_fetch"}, perf_fetch_cnt, 32'd0);
    chk({tag, "_perf_bubble"}, perf_bubble_cnt, 32'd0);
`endif
  endtask

  // Release reset and stream with a response every second cycle.
  task automatic run_stream(input string tag);
    mem_wait = 2;
    stall = 1'b0;
    seen_pc.delete();
    resp_addr.delete();
    reset_n = 1'b1;
    repeat (9) tick();
    chk({tag, "_resp_count"}, 32'(resp_addr.size() >= 3), 32'd1);
    chk({tag, "_seen_count"}, 32'(seen_pc.size() >= 3), 32'd1);
    if (resp_addr.size() >= 3 && seen_pc.size() >= 3) begin
      chk({tag, "_addr0"}, resp_addr[0], 16'h0000);
      chk({tag, "_addr1"}, resp_addr[1], 16'h0002);
      chk({tag, "_addr2"}, resp_addr[2], 16'h0004);
      chk({tag, "_pc0"}, seen_pc[0], 16'h0000);
      chk({tag, "_pc1"}, seen_pc[1], 16'h0002);
      chk({tag, "_pc2"}, seen_pc[2], 16'h0004);
    end
`ifdef IF_PERF_CNT_EN
    chk({tag, "_perf_fetch"}, perf_fetch_cnt, 32'd3);
    chk({tag, "_perf_bubble"}, perf_bubble_cnt, 32'd6);
`endif
  endtask

  initial begin
    int t;
    int n0;
    logic [15:0] ins0, pc0;
    reset_n = 1'b0; stall = 1'b0; br_taken = 1'b0; br_target = 16'h0000;
    tick(); tick();
    check_reset_values("reset");

    run_stream("stream");

    // Stall with a full slot while the next word arrives.
    mem_wait = 1;
    t = 0;
    while (if_valid !== 1'b1 && t < 50) begin tick(); t++; end
    chk("stall_wait_valid", 32'(t < 50), 32'd1);
    stall = 1'b1;
    ins0 = if_instruction;
    pc0 = if_pc;
    n0 = seen_pc.size();
    repeat (5) tick();
    chk("stall_read_low", imem_read, 1'b0);
    chk("stall_ins_kept", if_instruction, ins0);
    chk("stall_pc_kept", if_pc, pc0);
    stall = 1'b0;
    repeat (3) tick();
    chk("stall_seen_count", 32'(seen_pc.size() >= n0 + 2), 32'd1);
    if (seen_pc.size() >= n0 + 2) begin
      chk("stall_deliver0", seen_pc[n0], pc0);
      chk("stall_deliver1", seen_pc[n0+1], pc0 + 16'd2);
    end

    // Redirect while the request to 0006 is outstanding.
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    mem_wait = 3;
    t = 0;
    while (!(imem_read === 1'b1 && imem_address == 16'h0006) && t < 60) begin tick(); t++; end
    chk("redir_wait_0006", 32'(t < 60), 32'd1);
    br_taken = 1'b1; br_target = 16'h3000;
    tick();
    br_taken = 1'b0;
    chk("redir_hold_read", imem_read, 1'b1);
    chk("redir_hold_addr", imem_address, 16'h0006);
    chk("redir_slot_cleared", if_valid, 1'b0);
    tick();
    chk("redir_hold_addr2", imem_address, 16'h0006);
    t = 0;
    while (if_valid !== 1'b1 && t < 60) begin tick(); t++; end
    chk("redir_wait_valid", 32'(t < 60), 32'd1);
    chk("redir_first_pc", if_pc, 16'h3000);
    chk("redir_first_ins", if_instruction, word_of(16'h3000));

    // Redirect coinciding with a response while stalled.
    mem_wait = 1;
    chk("brresp_setup", 32'(if_valid === 1'b1 && imem_read === 1'b1), 32'd1);
    stall = 1'b1; br_taken = 1'b1; br_target = 16'h3001;
    tick();
    stall = 1'b0; br_taken = 1'b0;
    chk("brresp_valid_clear", if_valid, 1'b0);
    chk("brresp_read", imem_read, 1'b1);
    chk("brresp_addr", imem_address, 16'h3000);
    t = 0;
    while (if_valid !== 1'b1 && t < 60) begin tick(); t++; end
    chk("brresp_wait_valid", 32'(t < 60), 32'd1);
    chk("brresp_first_pc", if_pc, 16'h3000);

    // Reset pulse in the middle of a fetch, then the stream again.
    mem_wait = 3;
    tick();
    chk("midreset_read_before", imem_read, 1'b1);
    reset_n = 1'b0;
    tick();
    check_reset_values("midreset");
    run_stream("restream");

    chk("wrap_count", 32'(wrap_pc.size()), 32'd3);
    if (wrap_pc.size() == 3) begin
      chk("wrap_pc0", wrap_pc[0], 16'hFFFC);
      chk("wrap_pc1", wrap_pc[1], 16'hFFFE);
      chk("wrap_pc2", wrap_pc[2], 16'h0000);
      chk("wrap_p2_0", wrap_p2[0], 16'hFFFE);
      chk("wrap_p2_1", wrap_p2[1], 16'h0000);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks so far", n_pass, n_chk);
    $fatal(1);
  end

endmodule
